seg_scan_decoder: RTL and testbench

//  Decodes a time-multiplexed 8-digit 7-segment scan bus back into a 32-bit message.
//  The 32-bit message uses 8 nibbles: nibble i belongs to digit i.

---
 rtl/seg_scan_decoder.sv | 254 +++++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Rebuilds a 32-bit message from an 8-digit multiplexed 7-segment scan bus.
// Define SEG_HEX_DECODE_EN to also accept the A-F glyphs as legal digits.
module seg_scan_decoder #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  an_n,
   input  logic [7:0]  seg,
   input  logic        msg_ready,
   input  logic        ovf_clr,
   output logic        msg_valid,
   output logic [31:0] message,
   output logic [7:0]  msg_err,
   output logic [7:0]  blank_mask,
   output logic        overflow,
   output logic        frame_timeout
);

   localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_N     = CW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Returns {blank, err, nibble} for a 7-bit segment pattern.
   function automatic logic [5:0] decode_seg(input logic [6:0] p);
      logic [5:0] r;
      r = 6'b01_0000;
      case (p)
         7'h3F: r = 6'h00;
         7'h06: r = 6'h01;
         7'h5B: r = 6'h02;
         7'h4F: r = 6'h03;
         7'h66: r = 6'h04;
         7'h6D: r = 6'h05;
         7'h7D: r = 6'h06;
         7'h07: r = 6'h07;
         7'h7F: r = 6'h08;
         7'h6F: r = 6'h09;
`ifdef SEG_HEX_DECODE_EN
         7'h77: r = 6'h0A;
         7'h7C: r = 6'h0B;
         7'h39: r = 6'h0C;
         7'h5E: r = 6'h0D;
         7'h79: r = 6'h0E;
         7'h71: r = 6'h0F;
`endif
         7'h00: r = 6'b10_0000;
         default: r = 6'b01_0000;
      endcase
      return r;
   endfunction

   logic [7:0]    an_n_m_q, an_n_s_q;
   logic [7:0]    seg_m_q, seg_s_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [14:0]   prev_q, sample;
   logic [7:0]    mask_q, mask_d;
   logic [31:0]   nib_q, nib_d;
   logic [7:0]    err_q, err_d;
   logic [7:0]    blank_q, blank_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          msg_valid_q, msg_valid_d;
   logic [31:0]   message_q, message_d;
   logic [7:0]    msg_err_q, msg_err_d;
   logic [7:0]    blank_mask_q, blank_mask_d;
   logic          overflow_q, overflow_d;
   logic          frame_timeout_q, frame_timeout_d;

   logic          anode_ok;
   logic [2:0]    dig_idx;
   logic          capture;
   logic          complete, out_free, load, to_fire;
   logic [5:0]    dec;
   logic          unused_dp;

   // The decimal point never contributes to the decoded value.
   assign unused_dp = seg_s_q[7];
   assign sample    = {an_n_s_q, seg_s_q[6:0]};
   assign anode_ok  = $onehot(~an_n_s_q);
   assign dec       = decode_seg(seg_s_q[6:0]);

   always_comb begin
      dig_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!an_n_s_q[i]) dig_idx = 3'(i);
      end
   end

   // Dwell FSM: a digit is captured once its sample holds for STABLE_CYCLES.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (anode_ok) begin
               cnt_d = CW'(1);
               if (STABLE_CYCLES == 1) begin
                  capture = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_COUNT;
               end
            end
         end
         S_COUNT: begin
            if (sample == prev_q) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q + CW'(1) == STABLE_N) begin
                  capture = 1'b1;
                  state_d = S_DONE;
               end
            end else if (!anode_ok) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = CW'(1);
               if (STABLE_CYCLES == 1) begin
                  capture = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (sample != prev_q) begin
               if (!anode_ok) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_d = CW'(1);
                  if (STABLE_CYCLES == 1) begin
                     capture = 1'b1;
                  end else begin
                     state_d = S_COUNT;
                  end
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Frame assembly, timeout and output handshake.
   always_comb begin
      complete = (mask_q == 8'hFF);
      out_free = !msg_valid_q || msg_ready;
      load     = complete && out_free;
      to_fire  = 1'b0;
      to_cnt_d = to_cnt_q;
      mask_d   = complete ? 8'h00 : mask_q;
      nib_d    = nib_q;
      err_d    = err_q;
      blank_d  = blank_q;

      if ((TIMEOUT_CYCLES == 0) || (mask_q == 8'h00) || capture || complete) begin
         to_cnt_d = '0;
      end else if (to_cnt_q == TIMEOUT_LAST) begin
         to_fire  = 1'b1;
         to_cnt_d = '0;
      end else begin
         to_cnt_d = to_cnt_q + TW'(1);
      end
      if (to_fire) mask_d = 8'h00;

      // A new capture lands after any clear so the next frame can start at once.
      if (capture) begin
         nib_d[dig_idx*4 +: 4] = dec[3:0];
         err_d[dig_idx]        = dec[4];
         blank_d[dig_idx]      = dec[5];
         mask_d[dig_idx]       = 1'b1;
      end

      msg_valid_d  = msg_valid_q;
      message_d    = message_q;
      msg_err_d    = msg_err_q;
      blank_mask_d = blank_mask_q;
      if (load) begin
         msg_valid_d  = 1'b1;
         message_d    = nib_q;
         msg_err_d    = err_q;
         blank_mask_d = blank_q;
      end else if (msg_valid_q && msg_ready) begin
         msg_valid_d = 1'b0;
      end

      overflow_d = overflow_q;
      if (ovf_clr) overflow_d = 1'b0;
      if (complete && !out_free) overflow_d = 1'b1;

      frame_timeout_d = to_fire;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_n_m_q        <= 8'h00;
         an_n_s_q        <= 8'h00;
         seg_m_q         <= 8'h00;
         seg_s_q         <= 8'h00;
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         prev_q          <= '0;
         mask_q          <= 8'h00;
         nib_q           <= 32'h0;
         err_q           <= 8'h00;
         blank_q         <= 8'h00;
         to_cnt_q        <= '0;
         msg_valid_q     <= 1'b0;
         message_q       <= 32'h0;
         msg_err_q       <= 8'h00;
         blank_mask_q    <= 8'h00;
         overflow_q      <= 1'b0;
         frame_timeout_q <= 1'b0;
      end else begin
         an_n_m_q        <= an_n;
         an_n_s_q        <= an_n_m_q;
         seg_m_q         <= seg;
         seg_s_q         <= seg_m_q;
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         prev_q          <= sample;
         mask_q          <= mask_d;
         nib_q           <= nib_d;
         err_q           <= err_d;
         blank_q         <= blank_d;
         to_cnt_q        <= to_cnt_d;
         msg_valid_q     <= msg_valid_d;
         message_q       <= message_d;
         msg_err_q       <= msg_err_d;
         blank_mask_q    <= blank_mask_d;
         overflow_q      <= overflow_d;
         frame_timeout_q <= frame_timeout_d;
      end
   end

   assign msg_valid     = msg_valid_q;
   assign message       = message_q;
   assign msg_err       = msg_err_q;
   assign blank_mask    = blank_mask_q;
   assign overflow      = overflow_q;
   assign frame_timeout = frame_timeout_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scan-bus driver, expected-message queue
// popped by a handshake monitor, and direct checks of overflow/timeout/reset.
module tb_seg_scan_decoder;

   localparam int STABLE  = 4;
   localparam int TIMEOUT = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  an_n;
   logic [7:0]  seg;
   logic        msg_ready;
   logic        ovf_clr;
   logic        msg_valid;
   logic [31:0] message;
   logic [7:0]  msg_err;
   logic [7:0]  blank_mask;
   logic        overflow;
   logic        frame_timeout;

   logic [47:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   seg_scan_decoder #(
      .STABLE_CYCLES (STABLE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .an_n         (an_n),
      .seg          (seg),
      .msg_ready    (msg_ready),
      .ovf_clr      (ovf_clr),
      .msg_valid    (msg_valid),
      .message      (message),
      .msg_err      (msg_err),
      .blank_mask   (blank_mask),
      .overflow     (overflow),
      .frame_timeout(frame_timeout)
   );

   function automatic logic [7:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: return 8'h3F;
         4'd1: return 8'h06;
         4'd2: return 8'h5B;
         4'd3: return 8'h4F;
         4'd4: return 8'h66;
         4'd5: return 8'h6D;
         4'd6: return 8'h7D;
         4'd7: return 8'h07;
         4'd8: return 8'h7F;
         4'd9: return 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [63:0] pats_of(input logic [31:0] v);
      logic [63:0] p;
      for (int i = 0; i < 8; i++) p[8*i +: 8] = seg_of(v[4*i +: 4]);
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan_range(input logic [63:0] p, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         an_n = ~(8'h01 << i);
         seg  = p[8*i +: 8];
         tick(6);
      end
      an_n = 8'hFF;
      tick(4);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic count_timeouts(output int pulses);
      pulses = 0;
      for (int i = 0; i < 2 * TIMEOUT; i++) begin
         tick(1);
         if (frame_timeout) pulses++;
      end
   endtask

   // Monitor: every accepted message must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && msg_valid && msg_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_msg: got %h/%h/%h expected no message", message, msg_err, blank_mask);
         end else begin
            logic [47:0] e;
            e = exp_q.pop_front();
            if ({message, msg_err, blank_mask} === e) n_pass++;
            else $display("FAIL msg_compare: got %h expected %h", {message, msg_err, blank_mask}, e);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] p, pb;
      int          pulses;

      rst_n = 1'b0; an_n = 8'hFF; seg = 8'h00; msg_ready = 1'b1; ovf_clr = 1'b0;
      #1;
      check("reset_outputs", 64'({msg_valid, message, msg_err, blank_mask, overflow, frame_timeout}), 64'd0);
      tick(3);
      rst_n = 1'b1;
      tick(3);
      check("idle_after_reset", 64'({msg_valid, overflow, frame_timeout}), 64'd0);

      // Plain decimal frame
      exp_q.push_back({32'h12345678, 8'h00, 8'h00});
      scan_range(pats_of(32'h12345678), 0, 7);
      drain("drain_basic");

      // Hex glyphs on digits 3 and 6
      p = pats_of(32'h12345678);
      p[31:24] = 8'h77;
      p[55:48] = 8'h5E;
`ifdef SEG_HEX_DECODE_EN
      exp_q.push_back({32'h1D34A678, 8'h00, 8'h00});
`else
      exp_q.push_back({32'h10340678, 8'h48, 8'h00});
`endif
      scan_range(p, 0, 7);
      drain("drain_hex");

      // Blank, illegal pattern and decimal point
      p = pats_of(32'h98765432);
      p[23:16] = 8'h00;
      p[47:40] = 8'h01;
      p[55:48] = seg_of(4'd8) | 8'h80;
      exp_q.push_back({32'h98065032, 8'h20, 8'h04});
      scan_range(p, 0, 7);
      drain("drain_blank_err");

      // Toggling segments must not capture digit 0
      p = pats_of(32'h87654321);
      scan_range(p, 1, 7);
      an_n = 8'hFE;
      for (int k = 0; k < 20; k++) begin
         seg = (k % 2 == 1) ? 8'h06 : 8'h3F;
         tick(2);
      end
      an_n = 8'hFF;
      tick(10);
      check("toggle_no_capture", 64'(msg_valid), 64'd0);
      exp_q.push_back({32'h87654321, 8'h00, 8'h00});
      scan_range(p, 0, 0);
      drain("drain_toggle");

      // Two anodes active must not capture
      p = pats_of(32'h24681357);
      scan_range(p, 1, 7);
      an_n = 8'hFC;
      seg  = 8'h7F;
      tick(20);
      an_n = 8'hFF;
      tick(10);
      check("multi_hot_no_capture", 64'(msg_valid), 64'd0);
      exp_q.push_back({32'h24681357, 8'h00, 8'h00});
      scan_range(p, 0, 0);
      drain("drain_multi_hot");

      // Back-pressure: second frame dropped, overflow sticky until cleared
      msg_ready = 1'b0;
      p  = pats_of(32'h13572468);
      pb = pats_of(32'h86427531);
      exp_q.push_back({32'h13572468, 8'h00, 8'h00});
      scan_range(p, 0, 7);
      check("held_valid", 64'(msg_valid), 64'd1);
      scan_range(pb, 0, 7);
      check("overflow_set", 64'(overflow), 64'd1);
      check("held_message", 64'(message), 64'h13572468);
      ovf_clr = 1'b1;
      tick(1);
      ovf_clr = 1'b0;
      check("overflow_cleared", 64'(overflow), 64'd0);
      msg_ready = 1'b1;
      tick(3);
      check("single_accept", 64'(msg_valid), 64'd0);
      drain("drain_overflow");

      // Partial frame discarded on timeout
      p = pats_of(32'h11223344);
      scan_range(p, 0, 4);
      count_timeouts(pulses);
      check("timeout_pulses", 64'(pulses), 64'd1);
      exp_q.push_back({32'h11223344, 8'h00, 8'h00});
      scan_range(p, 0, 7);
      drain("drain_after_timeout");

      // Reset mid-frame drops the partial mask
      p = pats_of(32'h55667788);
      scan_range(p, 0, 3);
      #2 rst_n = 1'b0;
      #1;
      check("reset_mid_frame", 64'({msg_valid, message, msg_err, blank_mask, overflow, frame_timeout}), 64'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      scan_range(p, 4, 7);
      tick(6);
      check("reset_cleared_mask", 64'(msg_valid), 64'd0);
      count_timeouts(pulses);
      check("reset_partial_timeout", 64'(pulses), 64'd1);

      // Reset mid-handshake drops the pending message
      msg_ready = 1'b0;
      scan_range(pats_of(32'h90817263), 0, 7);
      check("hs_valid_before_reset", 64'(msg_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("reset_mid_handshake", 64'({msg_valid, message, msg_err, blank_mask, overflow, frame_timeout}), 64'd0);
      tick(2);
      rst_n = 1'b1;
      msg_ready = 1'b1;
      tick(3);
      check("no_msg_after_reset", 64'(msg_valid), 64'd0);
      exp_q.push_back({32'h31415926, 8'h00, 8'h00});
      scan_range(pats_of(32'h31415926), 0, 7);
      drain("drain_after_reset");

      tick(5);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
